// File: rtl/fourstate_scan_pkg.sv
// Shared types and the per-bit four-state classifier for the scan reader.
package fourstate_scan_pkg;

  typedef enum logic [1:0] {
    C0 = 2'b00,
    C1 = 2'b01,
    CX = 2'b10,
    CZ = 2'b11
  } code_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  // Case-equality keeps x and z distinguishable on four-state simulators.
  function automatic code_e classify(input logic b);
    if (b === 1'b0)      return C0;
    else if (b === 1'b1) return C1;
    else if (b === 1'bz) return CZ;
    else                 return CX;
  endfunction

endpackage

// File: rtl/fourstate_lane_classify.sv
// Combinational classifier for one LANE-bit slice: per-bit codes plus one/x/z tallies.
module fourstate_lane_classify
  import fourstate_scan_pkg::*;
#(
  parameter int LANE = 4,
  parameter int LCW  = $clog2(LANE + 1)
) (
  input  logic [LANE-1:0]   lane,
  output logic [2*LANE-1:0] code,
  output logic [LCW-1:0]    ones,
  output logic [LCW-1:0]    xs,
  output logic [LCW-1:0]    zs
);

  code_e c;

  always_comb begin
    code = '0;
    ones = '0;
    xs   = '0;
    zs   = '0;
    c    = C0;
    for (int i = 0; i < LANE; i++) begin
      c = classify(lane[i]);
      code[2*i +: 2] = c;
      if (c == C1) ones = ones + LCW'(1);
      if (c == CX) xs   = xs + LCW'(1);
      if (c == CZ) zs   = zs + LCW'(1);
    end
  end

endmodule

// File: rtl/fourstate_scan_reader.sv
// Snapshots a four-state bus and streams per-bit 0/1/x/z codes in LANE-bit beats.
// Optional macro FOURSTATE_SCAN_ERR_EN adds a sticky err output flagging any x/z.
module fourstate_scan_reader
  import fourstate_scan_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           bus_i,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*LANE-1:0]          out_code,
  output logic                       out_last,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] one_count,
  output logic [$clog2(WIDTH+1)-1:0] x_count,
  output logic [$clog2(WIDTH+1)-1:0] z_count
`ifdef FOURSTATE_SCAN_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int NB  = WIDTH / LANE;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int LCW = $clog2(LANE + 1);

  state_e             state, state_nxt;
  logic [BW-1:0]      beat;
  logic [WIDTH-1:0]   snap;
  logic [LANE-1:0]    lane_sel;
  logic [2*LANE-1:0]  lane_code;
  logic [LCW-1:0]     lane_ones, lane_xs, lane_zs;
  logic               last_beat;
  logic               accept;
  logic               capture;

  assign capture   = (state == IDLE) && start;
  assign accept    = (state == SCAN) && out_ready;
  assign last_beat = (beat == BW'(NB - 1));
  assign lane_sel  = snap[int'(beat)*LANE +: LANE];

  fourstate_lane_classify #(.LANE(LANE), .LCW(LCW)) u_lane (
    .lane (lane_sel),
    .code (lane_code),
    .ones (lane_ones),
    .xs   (lane_xs),
    .zs   (lane_zs)
  );

  // Snapshot is pure data; it only needs to be meaningful while scanning.
  always_ff @(posedge clk) begin
    if (capture) snap <= bus_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      one_count <= '0;
      x_count   <= '0;
      z_count   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        beat      <= '0;
        one_count <= '0;
        x_count   <= '0;
        z_count   <= '0;
      end else if (accept) begin
        beat      <= last_beat ? '0 : beat + BW'(1);
        one_count <= one_count + CW'(lane_ones);
        x_count   <= x_count + CW'(lane_xs);
        z_count   <= z_count + CW'(lane_zs);
      end
    end
  end

`ifdef FOURSTATE_SCAN_ERR_EN
  // Raised together with the move into DONE and held until the next capture.
  always_ff @(posedge clk) begin
    if (rst || capture) begin
      err <= 1'b0;
    end else if (accept && last_beat) begin
      err <= ((x_count + CW'(lane_xs)) != '0) || ((z_count + CW'(lane_zs)) != '0);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_code  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SCAN;
      end
      SCAN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_code  = lane_code;
        out_last  = last_beat;
        if (out_ready && last_beat) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fourstate_scan_reader.sv
// Scoreboard bench for fourstate_scan_reader: stimulus queues expected beats and counts,
// a negedge monitor pops and compares whenever a beat is accepted or done pulses.
module tb_fourstate_scan_reader;

  localparam int WIDTH = 16;
  localparam int LANE  = 4;
  localparam int NB    = WIDTH / LANE;
  localparam int CW    = $clog2(WIDTH + 1);

  logic                clk = 1'b0;
  logic                rst, start, out_ready;
  logic [WIDTH-1:0]    bus_i;
  logic                busy, out_valid, out_last, done;
  logic [2*LANE-1:0]   out_code;
  logic [CW-1:0]       one_count, x_count, z_count;
`ifdef FOURSTATE_SCAN_ERR_EN
  logic                err;
`endif

  fourstate_scan_reader #(.WIDTH(WIDTH), .LANE(LANE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus_i     (bus_i),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .done      (done),
    .one_count (one_count),
    .x_count   (x_count),
    .z_count   (z_count)
`ifdef FOURSTATE_SCAN_ERR_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*LANE-1:0] code;
    logic              last;
  } beat_t;

  typedef struct {
    int ones;
    int xs;
    int zs;
  } cnt_t;

  beat_t bq[$];
  cnt_t  cq[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  int    rand_rdy = 0;
  cnt_t  last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walk the bits of the value and bin each one by its four-state level.
  task automatic push_expect(input logic [WIDTH-1:0] v);
    beat_t b;
    cnt_t  c;
    c = '{0, 0, 0};
    for (int bt = 0; bt < NB; bt++) begin
      b.code = '0;
      for (int i = 0; i < LANE; i++) begin
        if (v[bt*LANE+i] === 1'b1) begin
          b.code[2*i +: 2] = 2'd1; c.ones++;
        end else if (v[bt*LANE+i] === 1'bz) begin
          b.code[2*i +: 2] = 2'd3; c.zs++;
        end else if (v[bt*LANE+i] === 1'bx) begin
          b.code[2*i +: 2] = 2'd2; c.xs++;
        end
      end
      b.last = (bt == NB - 1);
      bq.push_back(b);
    end
    cq.push_back(c);
    last_exp = c;
  endtask

  function automatic logic [WIDTH-1:0] rand4();
    logic [WIDTH-1:0] v;
    for (int k = 0; k < WIDTH; k++) begin
      case ($urandom_range(3))
        0: v[k] = 1'b0;
        1: v[k] = 1'b1;
        2: v[k] = 1'bx;
        default: v[k] = 1'bz;
      endcase
    end
    return v;
  endfunction

  // Monitor: compares accepted beats, stall stability and completion counts.
  initial begin
    logic              prev_stall;
    logic [2*LANE-1:0] prev_code;
    logic              prev_last;
    logic [CW-1:0]     prev_one;
    beat_t             b;
    cnt_t              c;
    prev_stall = 1'b0;
    prev_code  = '0;
    prev_last  = 1'b0;
    prev_one   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_code", 32'(out_code), 32'(prev_code));
        check("stall_last", 32'(out_last), 32'(prev_last));
        check("stall_ones", 32'(one_count), 32'(prev_one));
      end
      prev_stall = out_valid && !out_ready;
      prev_code  = out_code;
      prev_last  = out_last;
      prev_one   = one_count;
      if (out_valid && out_ready) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got code %0h expected no beat", out_code);
        end else begin
          b = bq.pop_front();
          check("beat_code", 32'(out_code), 32'(b.code));
          check("beat_last", 32'(out_last), 32'(b.last));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_valid_low", 32'(out_valid), 32'd0);
        if (cq.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          c = cq.pop_front();
          check("one_count", 32'(one_count), 32'(c.ones));
          check("x_count", 32'(x_count), 32'(c.xs));
          check("z_count", 32'(z_count), 32'(c.zs));
`ifdef FOURSTATE_SCAN_ERR_EN
          check("err_done", 32'(err), 32'((c.xs + c.zs) != 0));
`endif
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy != 0) out_ready = ($urandom_range(3) != 0);
    end
  end

  // mode 0: plain, 1: 3-cycle stall on beat 2, 2: start pulse and bus toggling mid-scan
  task automatic run(input logic [WIDTH-1:0] v, input int mode, output int lat);
    int n;
    @(posedge clk);
    #1;
    push_expect(v);
    bus_i = v;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
`ifdef FOURSTATE_SCAN_ERR_EN
      if (n == 1) check("err_cleared_on_start", 32'(err), 32'd0);
`endif
      if (mode == 1) begin
        if (n == 3) out_ready = 1'b0;
        if (n == 6) out_ready = 1'b1;
      end else if (mode == 2) begin
        bus_i = WIDTH'($urandom);
        if (n == 2) start = 1'b1;
      end
      @(negedge clk);
    end while (!done && n < 200);
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
    lat = n;
    if (mode == 2) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int dc;
    logic [WIDTH-1:0] fs;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    bus_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(out_code), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ones", 32'(one_count), 32'd0);
    check("rst_xs", 32'(x_count), 32'd0);
    check("rst_zs", 32'(z_count), 32'd0);
`ifdef FOURSTATE_SCAN_ERR_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;

    run(16'h00FF, 0, lat);
    check("latency_plain", 32'(lat), 32'(NB + 1));
    @(negedge clk);
    check("ones_hold_idle", 32'(one_count), 32'(last_exp.ones));
    check("busy_idle", 32'(busy), 32'd0);

    fs = 16'h0000;
    fs[5] = 1'bx;
    fs[12] = 1'bz;
    run(fs, 0, lat);
    check("latency_fourstate", 32'(lat), 32'(NB + 1));
    repeat (2) @(negedge clk);
    check("xs_hold_idle", 32'(x_count), 32'(last_exp.xs));
    check("zs_hold_idle", 32'(z_count), 32'(last_exp.zs));
`ifdef FOURSTATE_SCAN_ERR_EN
    check("err_sticky", 32'(err), 32'((last_exp.xs + last_exp.zs) != 0));
`endif

    run(16'h00FF, 1, lat);
    check("latency_stall", 32'(lat), 32'(NB + 4));
`ifdef FOURSTATE_SCAN_ERR_EN
    @(negedge clk);
    check("err_clean", 32'(err), 32'd0);
`endif

    dc = done_cnt;
    run(rand4(), 2, lat);
    check("latency_ignore", 32'(lat), 32'(NB + 1));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("ignored_start_idle", 32'(busy), 32'd0);
    check("ignored_start_done_cnt", 32'(done_cnt - dc), 32'd1);

    // Reset during beat 2: partial stream is dropped and no done follows.
    @(posedge clk);
    #1;
    push_expect(16'h1234);
    bus_i = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bq.delete();
    cq.delete();
    dc = done_cnt;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ones", 32'(one_count), 32'd0);
    check("midrst_xs", 32'(x_count), 32'd0);
    check("midrst_zs", 32'(z_count), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc), 32'd0);

    run(16'hA5C3, 0, lat);
    check("latency_after_rst", 32'(lat), 32'(NB + 1));

    rand_rdy = 1;
    for (int t = 0; t < 25; t++) run(rand4(), 0, lat);
    rand_rdy = 0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("beats_drained", 32'(bq.size()), 32'd0);
    check("counts_drained", 32'(cq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fourstate_scan_reader.md
Name: fourstate_scan_reader

Overview:
- Reader end for the four-state constant-pattern buses that generated test modules drive onto packed/unpacked nets.
- Snapshots a WIDTH-bit logic bus on request and streams a per-bit 0/1/x/z classification out in LANE-bit beats over a valid/ready handshake.
- Accumulates one/x/z counts and reports them with a completion pulse.
- Used in self-checking benches placed downstream of generated modules.

Parameters:
- WIDTH, 16, bits sampled per snapshot; must be a multiple of LANE.
- LANE, 4, bits classified per output beat; 1 <= LANE <= WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request snapshot; honoured only in IDLE.
- bus_i  input  WIDTH  four-state logic bus under inspection.
- busy  output  1  high in SCAN and DONE.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- out_code  output  2*LANE  per-bit codes; bits [2i+1:2i] = code of bit beat*LANE+i.
- out_last  output  1  current beat is the final beat.
- done  output  1  one-cycle completion pulse.
- one_count  output  $clog2(WIDTH+1)  number of 1 bits in snapshot.
- x_count  output  $clog2(WIDTH+1)  number of x bits.
- z_count  output  $clog2(WIDTH+1)  number of z bits.

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Codes: 2'b00 = 0, 2'b01 = 1, 2'b10 = x, 2'b11 = z. Classification uses case-equality, so the snapshot register is four-state logic.
- Reset values: busy=0, out_valid=0, out_code=0, out_last=0, done=0, all counts=0, state=IDLE, beat=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On start=1, capture bus_i into snap, clear beat and counts, go to SCAN.
  - out_valid rises the next cycle; start-to-first-beat latency is 1 cycle.
- SCAN:
  - out_valid=1. out_code is combinational from snap lane[beat].
  - out_last=1 when beat == WIDTH/LANE-1.
  - On out_valid && out_ready: add the lane's one/x/z counts and increment beat.
  - If the accepted beat is the last one, go to DONE.
  - Without out_ready, out_code, out_last and the counts hold stable.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, then go to IDLE.
  - Counts hold their final values until the next accepted start.
- start while busy is ignored, not queued. Changes on bus_i after capture have no effect.
- start on the same cycle DONE returns to IDLE is ignored; start is sampled only while in IDLE.
- Width: counts saturate naturally because their maximum is WIDTH. beat is $clog2(WIDTH/LANE), with a minimum of 1 bit.
- Reset mid-scan: the next cycle is IDLE with all outputs at reset values. The partial stream is abandoned and no done pulse is issued.
- Throughput: with out_ready held high, WIDTH/LANE beats take consecutive cycles and done follows one cycle after the last beat.

Optional Feature:
- Macro: FOURSTATE_SCAN_ERR_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - err=1 in the DONE cycle when x_count+z_count != 0.
  - err stays sticky until the next accepted start or rst.
- Undefined: the err port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package fourstate_scan_pkg holds:
  - enum code_e {C0, C1, CX, CZ} (2-bit).
  - enum state_e {IDLE, SCAN, DONE}.
  - function classify(logic b) returning code_e.
- Sub-module fourstate_lane_classify: one lane of LANE bits in; outputs 2*LANE codes and that lane's one/x/z counts. It is purely combinational and instantiated once on the selected lane.

Test Plan (WIDTH=16, LANE=4):
- Known pattern: bus_i=16'h00FF, start, out_ready=1.
  - Expected beats 0..3: out_code=8'h55, 8'h55, 8'h00, 8'h00.
  - out_last on beat 3; done one cycle later.
  - one_count=8, x_count=0, z_count=0.
- Four-state pattern: bus_i=16'h0000 with bit5=x and bit12=z.
  - Beat1 out_code=8'b00_00_10_00; beat3 out_code=8'b00_00_00_11.
  - x_count=1, z_count=1, one_count=0.
- Backpressure: out_ready low for 3 cycles during beat 2.
  - out_valid stays 1 and out_code and counts stay stable.
  - Stream resumes at beat 2 and done arrives 3 cycles later than the unstalled run.
- Ignored start and bus changes: start pulsed in SCAN and bus_i toggled after capture.
  - Stream matches the original snapshot.
  - Exactly one done pulse; no second scan begins.
- Reset mid-scan: rst during beat 2.
  - Next cycle busy=0, out_valid=0, counts=0, no done pulse.
  - A subsequent start scans normally.
- With FOURSTATE_SCAN_ERR_EN defined:
  - The four-state case gives err=1 from DONE onward, cleared by the next start.
  - The 16'h00FF case gives err=0.
